// File: rtl/bus_dest_bank_if.sv
// Bus-side signal bundle for the destination register bank: the write word,
// destination/read selects and control inputs, plus the read-back and
// architectural outputs. The bank is the slave; whoever drives the bus
// (datapath control or a testbench) uses the master view.
interface bus_dest_bank_if;
    logic [31:0] BusMuxOut;
    logic        dest_we;
    logic [4:0]  dest_sel;
    logic [4:0]  rd_a_sel;
    logic [4:0]  rd_b_sel;
    logic        ba_mode;
    logic        err_clr;
    logic [31:0] rd_a_data;
    logic [31:0] rd_b_data;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] out_port;
    logic        err_illegal;
    logic [15:0] wr_count;

    modport master (
        output BusMuxOut, dest_we, dest_sel, rd_a_sel, rd_b_sel, ba_mode, err_clr,
        input  rd_a_data, rd_b_data, hi_q, lo_q, out_port, err_illegal, wr_count
    );

    modport slave (
        input  BusMuxOut, dest_we, dest_sel, rd_a_sel, rd_b_sel, ba_mode, err_clr,
        output rd_a_data, rd_b_data, hi_q, lo_q, out_port, err_illegal, wr_count
    );
endinterface

// File: rtl/bus_dest_bank.sv
// Destination register bank: R0-R15, HI, LO and the output port (codes 0-18).
// Writes are captured into a one-entry pending stage and committed to the
// architectural register on the following edge. Both read ports bypass from
// the pending stage, so a word is readable the cycle right after its capture
// edge. Codes 19-31 are illegal: they write nothing and raise a sticky flag.
module bus_dest_bank (
    input  logic            clk,
    input  logic            clr_n,
    bus_dest_bank_if.slave  bus
);
    localparam int          NUM_DEST  = 19;
    localparam logic [4:0]  LAST_CODE = 5'd18;

    // Architectural registers, gathered from the per-register generate blocks.
    logic [31:0] w_regs [NUM_DEST];

    // Pending (captured but not yet committed) write.
    logic        r_pend_v;
    logic [4:0]  r_pend_sel;
    logic [31:0] r_pend_data;

    logic        r_err_illegal;
    logic [15:0] r_wr_count;

    logic        w_cap_ok;
    logic        w_illegal;

    assign w_cap_ok  = bus.dest_we && (bus.dest_sel <= LAST_CODE);
    assign w_illegal = bus.dest_we && (bus.dest_sel >  LAST_CODE);

    // Capture stage: a legal request fills the pending slot, anything else empties it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pend_v    <= 1'b0;
            r_pend_sel  <= '0;
            r_pend_data <= '0;
        end else begin
            r_pend_v <= w_cap_ok;
            if (w_cap_ok) begin
                r_pend_sel  <= bus.dest_sel;
                r_pend_data <= bus.BusMuxOut;
            end
        end
    end

    // One storage register per destination; each commits when the pending slot targets it.
    for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_reg
        logic [31:0] r_q;

        // Commit stage for destination gi.
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                r_q <= '0;
            end else if (r_pend_v && (r_pend_sel == 5'(gi))) begin
                r_q <= r_pend_data;
            end
        end

        assign w_regs[gi] = r_q;
    end

    // Count committed writes, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wr_count <= '0;
        end else if (r_pend_v && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    // Sticky illegal-code flag; a new illegal request beats a simultaneous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_err_illegal <= 1'b0;
        end else if (w_illegal) begin
            r_err_illegal <= 1'b1;
        end else if (bus.err_clr) begin
            r_err_illegal <= 1'b0;
        end
    end

    // Two identical read ports; the bypass looks only at registered pending state.
    logic [4:0]  w_rd_sel  [2];
    logic [31:0] w_rd_data [2];

    assign w_rd_sel[0] = bus.rd_a_sel;
    assign w_rd_sel[1] = bus.rd_b_sel;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        // Read mux: base-address mask, illegal code, bypass, then architectural value.
        always_comb begin
            w_rd_data[gi] = '0;
            if (bus.ba_mode && (w_rd_sel[gi] == 5'd0)) begin
                w_rd_data[gi] = '0;
            end else if (w_rd_sel[gi] > LAST_CODE) begin
                w_rd_data[gi] = '0;
            end else if (r_pend_v && (w_rd_sel[gi] == r_pend_sel)) begin
                w_rd_data[gi] = r_pend_data;
            end else begin
                w_rd_data[gi] = w_regs[w_rd_sel[gi]];
            end
        end
    end

    assign bus.rd_a_data   = w_rd_data[0];
    assign bus.rd_b_data   = w_rd_data[1];
    assign bus.hi_q        = w_regs[16];
    assign bus.lo_q        = w_regs[17];
    assign bus.out_port    = w_regs[18];
    assign bus.err_illegal = r_err_illegal;
    assign bus.wr_count    = r_wr_count;
endmodule
